// File: rtl/tlp_wrr_scheduler.sv
// -----------------------------------------------------------------------------
// tlp_wrr_scheduler
//
// Weighted round-robin scheduler for the four TLP source queues that share the
// transmit datapath. The scheduler walks a host-programmable ownership table.
// It grants the owner of a slot only when that queue is requesting and has
// link credit. It offers one grant at a time on a valid/ready handshake.
//
// Handshake: the grant (gnt_valid/gnt_id) is raised by the scheduler and held
// unchanged until the cycle in which gnt_ready is also high. That cycle is the
// transfer: pop pulses one-hot for the granted queue, the queue's credit is
// consumed, and gnt_valid drops on the following edge. gnt_ready has no effect
// while gnt_valid is low.
//
// Optional build macro: WRR_LOOKAHEAD_EN. When defined, SCAN searches every
// table slot in one cycle, starting at slot_ptr. When undefined, SCAN checks one
// slot per cycle.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   req[3:0]    in   level, queue i has a TLP pending
//   credit_ret  in   pulse, link returned one credit for queue i
//   cfg_we      in   table write strobe
//   cfg_addr    in   slot index to write
//   cfg_data    in   owner id written to the slot
//   gnt_ready   in   datapath accepts the current grant
//   gnt_valid   out  grant outstanding
//   gnt_id      out  granted queue id
//   pop[3:0]    out  one-hot pop on handshake (combinational)
//   slot_ptr    out  next slot to be examined (debug)
// -----------------------------------------------------------------------------
module tlp_wrr_scheduler #(
    parameter int NUM_SLOTS   = 16,
    parameter int SLOT_W      = 4,
    parameter int CREDIT_W    = 4,
    parameter int CREDIT_INIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [3:0]        credit_ret,
    input  logic              cfg_we,
    input  logic [SLOT_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_data,
    input  logic              gnt_ready,
    output logic              gnt_valid,
    output logic [1:0]        gnt_id,
    output logic [3:0]        pop,
    output logic [SLOT_W-1:0] slot_ptr
);

    typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};

    state_e              state_q, state_d;
    logic [1:0]          gnt_id_q, gnt_id_d;
    logic [SLOT_W-1:0]   slot_ptr_q, slot_ptr_d;
    logic [CREDIT_W-1:0] credit_q [4];
    logic [CREDIT_W-1:0] credit_d [4];
    logic [1:0]          table_q [NUM_SLOTS];
    logic [3:0]          eligible;
    logic                handshake;

`ifdef WRR_LOOKAHEAD_EN
    logic                found;
    logic [SLOT_W-1:0]   idx;
    logic [SLOT_W-1:0]   found_slot;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req[i] && (credit_q[i] != '0);
        end
    end

    // A grant in flight during a reset edge is dropped, so no pop is shown.
    assign handshake = (state_q == HOLD) && gnt_ready && !reset;

    assign gnt_valid = (state_q == HOLD);
    assign gnt_id    = gnt_id_q;
    assign slot_ptr  = slot_ptr_q;
    assign pop       = handshake ? (4'b0001 << gnt_id_q) : 4'b0000;

    // Next-state logic for the FSM.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        slot_ptr_d = slot_ptr_q;
`ifdef WRR_LOOKAHEAD_EN
        found      = 1'b0;
        idx        = slot_ptr_q;
        found_slot = slot_ptr_q;
`endif
        case (state_q)
            SCAN: begin
`ifdef WRR_LOOKAHEAD_EN
                // The first eligible owner in wrap-around order from slot_ptr wins.
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    idx = slot_ptr_q + SLOT_W'(k);
                    if (!found && eligible[table_q[idx]]) begin
                        found      = 1'b1;
                        found_slot = idx;
                    end
                end
                if (found) begin
                    state_d    = HOLD;
                    gnt_id_d   = table_q[found_slot];
                    slot_ptr_d = found_slot + SLOT_W'(1);
                end
`else
                if (eligible[table_q[slot_ptr_q]]) begin
                    state_d  = HOLD;
                    gnt_id_d = table_q[slot_ptr_q];
                end
                slot_ptr_d = slot_ptr_q + SLOT_W'(1);
`endif
            end
            HOLD: begin
                if (gnt_ready) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Credit update: a simultaneous return and consume cancel each other.
    // Returns above the maximum are discarded.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            credit_d[i] = credit_q[i];
            if (handshake && (gnt_id_q == 2'(i)) && !credit_ret[i]) begin
                credit_d[i] = credit_q[i] - CREDIT_W'(1);
            end else if (credit_ret[i] && !(handshake && (gnt_id_q == 2'(i)))
                         && (credit_q[i] != CREDIT_MAX)) begin
                credit_d[i] = credit_q[i] + CREDIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCAN;
            gnt_id_q   <= 2'd0;
            slot_ptr_q <= '0;
            for (int i = 0; i < 4; i++) begin
                credit_q[i] <= CREDIT_W'(CREDIT_INIT);
            end
            for (int k = 0; k < NUM_SLOTS; k++) begin
                table_q[k] <= 2'(k);
            end
        end else begin
            state_q    <= state_d;
            gnt_id_q   <= gnt_id_d;
            slot_ptr_q <= slot_ptr_d;
            for (int i = 0; i < 4; i++) begin
                credit_q[i] <= credit_d[i];
            end
            // The scan in this cycle has already read the old entry.
            if (cfg_we) begin
                table_q[cfg_addr] <= cfg_data;
            end
        end
    end

endmodule

// File: doc/tlp_wrr_scheduler.md
Name: tlp_wrr_scheduler

Overview:
- Weighted round-robin scheduler for the 4 TLP source queues that share the transmit datapath.
- Walks a programmable 16-slot ownership table, checks each slot owner's request and link credits, and issues one grant at a time over a valid/ready handshake.
- Each accepted grant pulses a one-hot pop to the owning queue FIFO.
- Sits between the per-queue FIFOs and the TLP transmit mux; the host configures the table.

Parameters:
- NUM_SLOTS, 16, table depth; must be a power of 2.
- SLOT_W, 4, slot pointer / config address width; equals log2(NUM_SLOTS).
- CREDIT_W, 4, per-queue credit counter width.
- CREDIT_INIT, 4, credit value loaded at reset; must be at most 2^CREDIT_W-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  level; bit i = queue i has a TLP pending.
- credit_ret  in  4  1-cycle pulse; bit i = link returned one credit for queue i.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  SLOT_W  slot to write.
- cfg_data  in  2  owner id written to the slot.
- gnt_ready  in  1  datapath accepts the current grant.
- gnt_valid  out  1  grant outstanding.
- gnt_id  out  2  granted queue id.
- pop  out  4  one-hot pop; equals decode(gnt_id) when gnt_valid&gnt_ready, else 0 (combinational).
- slot_ptr  out  SLOT_W  next slot to be examined (debug).

Behaviour:
- Reset, at the first posedge with reset=1:
  - gnt_valid=0, gnt_id=0, slot_ptr=0.
  - All credits = CREDIT_INIT.
  - table[k] = k mod 4.
  - FSM = SCAN.
  - pop=0 while gnt_valid=0.
- Reset mid-grant: the outstanding grant is dropped, with no credit decrement and no pop.
- Eligibility of queue i: req[i]=1 and credit[i]!=0, using registered credit values of the current cycle.
- FSM SCAN (one slot per cycle):
  - owner = table[slot_ptr].
  - If the owner is eligible: gnt_valid<=1, gnt_id<=owner, go to HOLD.
  - slot_ptr <= slot_ptr+1 in both cases, wrapping 15->0.
- FSM HOLD:
  - gnt_valid and gnt_id are held stable until gnt_valid&gnt_ready.
  - On handshake: pop asserted that cycle, credit[gnt_id] decremented, gnt_valid<=0, return to SCAN.
  - slot_ptr frozen while in HOLD.
- The grant is sticky: a req deassertion during HOLD does not cancel it.
- Throughput: maximum one grant per 2 cycles.
- Latency from req to gnt_valid is 1 to NUM_SLOTS cycles (without lookahead).
- Credit update per queue, per cycle:
  - Handshake only: -1.
  - credit_ret only: +1, saturating at 2^CREDIT_W-1 (extra returns discarded).
  - Both: unchanged.
- A counter never underflows, because a grant requires a nonzero credit.
- Table write: table[cfg_addr]<=cfg_data on the clock edge.
  - A SCAN in the same cycle reads the old entry.
  - An outstanding grant is unaffected.
  - Writes are accepted in any state, but not during reset.
- No eligible queue: SCAN keeps cycling slot_ptr, gnt_valid stays 0.

Optional Feature:
- Macro: WRR_LOOKAHEAD_EN.
- Defined: SCAN examines all NUM_SLOTS slots in one cycle, starting at slot_ptr (order slot_ptr, slot_ptr+1, ..., wrapping).
  - Grants the first eligible owner and sets slot_ptr to that slot+1.
  - If none is eligible, slot_ptr holds.
  - Latency from eligibility to gnt_valid is exactly 1 cycle.
- Not defined: single-slot scan as above.
- Grant ordering under continuous eligibility is identical in both modes.

Test Plan:
- Reset, req=4'b1111, gnt_ready=1, no credit_ret -> gnt_id sequence 0,1,2,3 repeating for 16 grants; pop one-hot matches gnt_id; all credits reach 0; then gnt_valid stays 0.
- req=4'b0001 only, gnt_ready=1 -> exactly 4 grants to id 0, then none; one credit_ret[0] pulse -> exactly one more grant to id 0.
- Write table slots 0-11 = 0 and slots 12-15 = 1; req=4'b0011; credit_ret pulsed on every pop -> 16 consecutive grants split 12 to id 0 and 4 to id 1, in slot order.
- Grant outstanding with gnt_ready=0 for 5 cycles -> gnt_valid=1 and gnt_id stable; pop=0; credit and slot_ptr unchanged; req[id] dropped mid-hold does not cancel; gnt_ready=1 -> single pop, credit-1.
- credit_ret[i] in the same cycle as handshake on i -> credit unchanged; credit_ret[i] with credit=15 -> stays 15.
- Assert reset while gnt_valid=1 -> next cycle gnt_valid=0, slot_ptr=0, credits=4, table default; no pop on the reset cycle. With WRR_LOOKAHEAD_EN, req=4'b1000 from slot_ptr=0 -> grant id 3 one cycle later, slot_ptr=4.
